// File: rtl/scarv_cop_pmul_seq.sv
// scarv_cop_pmul_seq
//   Sequential packed (SIMD) multiplier. The XLEN-bit operands are split into
//   lanes of LW = XLEN >> pw bits; every lane is multiplied independently,
//   either as an ordinary unsigned multiply or as a carry-less (GF(2)) one,
//   consuming SPC multiplier bits per lane per cycle. The low or high LW bits
//   of each 2*LW lane product are packed back into result.
//
// Ports
//   g_clk     clock, all state on the rising edge
//   g_resetn  asynchronous active-low reset
//   start     request a new operation (taken when ready and not flush)
//   flush     abandon any operation in flight, back to idle
//   a, b      LHS / RHS operands (latched on accept)
//   pw        pack width, LW = XLEN >> pw
//   high      return the upper LW bits of each lane product
//   ncarry    carry-less multiply
//   ready     block can accept start this cycle
//   done      one-cycle pulse, result valid
//   result    packed product, held until the next completion or reset
module scarv_cop_pmul_seq #(
  parameter int XLEN = 32,
  parameter int SPC  = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      pw,
  input  logic            high,
  input  logic            ncarry,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int LOG     = $clog2(XLEN);
  localparam int SPC_LOG = $clog2(SPC);
  localparam int AW      = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   acc_reg, acc_step;
  logic [AW-1:0]   a_sh_reg, a_spread;
  logic [XLEN-1:0] b_sh_reg;
  logic [XLEN-1:0] result_reg, result_next;
  logic [LOG-1:0]  count_reg, count_load;
  logic [2:0]      pw_reg, pw_eff;
  logic            high_reg, ncarry_reg, illegal_reg;
  logic            pw_legal, accept;
  int              lw_raw, lw_in, lw_reg;

  assign lw_raw   = XLEN >> pw;
  assign pw_legal = (lw_raw >= 2) && (lw_raw >= SPC);
  // An illegal pack width is replaced by 0 so every lane index below stays
  // in range; the illegal flag forces the result to zero anyway.
  assign pw_eff   = pw_legal ? pw : 3'd0;
  assign lw_in    = XLEN >> pw_eff;
  assign lw_reg   = XLEN >> pw_reg;
  assign count_load = pw_legal ? LOG'((lw_in >> SPC_LOG) - 1) : '0;
  assign accept   = start && ready && !flush;

  // Spread each LW-bit lane of a into the low half of a 2*LW accumulator
  // lane, so the shifted multiplicand grows inside its own lane.
  always_comb begin
    int lane, k;
    lane     = 0;
    k        = 0;
    a_spread = '0;
    for (int j = 0; j < AW; j++) begin
      lane = j >> (LOG + 1 - int'(pw_eff));
      k    = j - lane * 2 * lw_in;
      if (k < lw_in) a_spread[j] = a[lane * lw_in + k];
    end
  end

  // One RUN step: for each of the SPC multiplier bits, gate the shifted
  // multiplicand of every lane by that lane's current b bit and accumulate.
  // Partial sums never exceed the final lane product (< 2^(2LW)), so a plain
  // full-width add cannot carry across a lane boundary.
  always_comb begin
    int lane;
    logic [AW-1:0] term;
    lane     = 0;
    term     = '0;
    acc_step = acc_reg;
    for (int s = 0; s < SPC; s++) begin
      term = '0;
      for (int j = s; j < AW; j++) begin
        lane    = j >> (LOG + 1 - int'(pw_reg));
        term[j] = a_sh_reg[j - s] & b_sh_reg[lane * lw_reg + s];
      end
      if (ncarry_reg) acc_step = acc_step ^ term;
      else            acc_step = acc_step + term;
    end
  end

  // Pick the low or high half of each lane product and pack it.
  always_comb begin
    int lane, k;
    lane        = 0;
    k           = 0;
    result_next = '0;
    for (int r = 0; r < XLEN; r++) begin
      lane = r >> (LOG - int'(pw_reg));
      k    = r - lane * lw_reg;
      result_next[r] = acc_step[lane * 2 * lw_reg + k + (high_reg ? lw_reg : 0)];
    end
    if (illegal_reg) result_next = '0;
  end

  // State register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_reg <= S_IDLE;
    else           state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (count_reg == '0) state_next = S_DONE;
      S_DONE:  state_next = accept ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Outputs
  always_comb begin
    ready = (state_reg != S_RUN);
    done  = (state_reg == S_DONE);
  end

  assign result = result_reg;

  // Datapath
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      acc_reg     <= '0;
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      count_reg   <= '0;
      result_reg  <= '0;
      pw_reg      <= '0;
      high_reg    <= 1'b0;
      ncarry_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (accept) begin
      acc_reg     <= '0;
      a_sh_reg    <= a_spread;
      b_sh_reg    <= b;
      count_reg   <= count_load;
      pw_reg      <= pw_eff;
      high_reg    <= high;
      ncarry_reg  <= ncarry;
      illegal_reg <= !pw_legal;
    end else if (state_reg == S_RUN && !flush) begin
      acc_reg  <= acc_step;
      a_sh_reg <= a_sh_reg << SPC;
      b_sh_reg <= b_sh_reg >> SPC;
      if (count_reg == '0) result_reg <= result_next;
      else                 count_reg  <= count_reg - LOG'(1);
    end
  end

endmodule

// File: tb/tb_scarv_cop_pmul_seq.sv
// Self-checking bench for scarv_cop_pmul_seq. Two instances (SPC=1 and SPC=4,
// XLEN=32) share all inputs; each is checked against a lane-by-lane
// arithmetic reference model for result and accept->done latency.
module tb_scarv_cop_pmul_seq;

  logic        g_clk, g_resetn, start, flush, high, ncarry;
  logic [31:0] a, b;
  logic [2:0]  pw;
  logic        ready1, done1, ready4, done4;
  logic [31:0] res1, res4;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev1, prev4;

  scarv_cop_pmul_seq #(.XLEN(32), .SPC(1)) dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start), .flush(flush),
    .a(a), .b(b), .pw(pw), .high(high), .ncarry(ncarry),
    .ready(ready1), .done(done1), .result(res1)
  );

  scarv_cop_pmul_seq #(.XLEN(32), .SPC(4)) dut4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start), .flush(flush),
    .a(a), .b(b), .pw(pw), .high(high), .ncarry(ncarry),
    .ready(ready4), .done(done4), .result(res4)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: split into lanes, multiply each with plain arithmetic.
  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input int p, input bit hv, input bit nv,
                                        input int spc, output int lat);
    int lw;
    logic [63:0] m, x, y, prod;
    logic [31:0] r;
    lw = 32 >> p;
    r  = '0;
    if (lw < 2 || lw < spc) begin
      lat = 2;
      return 32'h0;
    end
    lat = lw / spc + 1;
    m = (64'd1 << lw) - 64'd1;
    for (int i = 0; i < 32 / lw; i++) begin
      x = (64'(av) >> (i * lw)) & m;
      y = (64'(bv) >> (i * lw)) & m;
      if (nv) begin
        prod = '0;
        for (int k = 0; k < lw; k++) if (y[k]) prod = prod ^ (x << k);
      end else begin
        prod = x * y;
      end
      if (hv) prod = prod >> lw;
      r = r | 32'((prod & m) << (i * lw));
    end
    return r;
  endfunction

  // Issue one operation and check both instances; returns the SPC=1 result.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] pv,
                       input bit hv, input bit nv, input bit poke, output logic [31:0] r1);
    logic [31:0] e1, e4, r4;
    int l1, l4, got1, got4;
    e1 = model(av, bv, int'(pv), hv, nv, 1, l1);
    e4 = model(av, bv, int'(pv), hv, nv, 4, l4);
    r1 = '0;
    r4 = '0;
    got1 = -1;
    got4 = -1;
    @(negedge g_clk);
    a = av; b = bv; pw = pv; high = hv; ncarry = nv; start = 1'b1;
    @(negedge g_clk);
    start = 1'b0;
    // Operands are scrambled after accept; the DUT must not care.
    a = $urandom; b = $urandom; pw = 3'($urandom); high = 1'($urandom); ncarry = 1'($urandom);
    check("busy_ready", 64'(ready1), 64'(0));
    for (int cyc = 1; cyc <= 200 && (got1 < 0 || got4 < 0); cyc++) begin
      if (poke && cyc == 3) begin start = 1'b1; a = $urandom; b = $urandom; pw = 3'd0; end
      if (poke && cyc == 4) start = 1'b0;
      if (done1 && got1 < 0) begin got1 = cyc; r1 = res1; end
      if (done4 && got4 < 0) begin got4 = cyc; r4 = res4; end
      if (got1 < 0 || got4 < 0) @(negedge g_clk);
    end
    start = 1'b0;
    check("lat_spc1", 64'(got1), 64'(l1));
    check("lat_spc4", 64'(got4), 64'(l4));
    check("res_spc1", 64'(r1), 64'(e1));
    check("res_spc4", 64'(r4), 64'(e4));
    @(negedge g_clk);
    check("done_pulse", {62'd0, done1, done4}, 64'd0);
    check("ready_after", {62'd0, ready1, ready4}, 64'd3);
    $display("[TB] op a=%h b=%h pw=%0d high=%0d nc=%0d -> spc1 %h (lat %0d) spc4 %h (lat %0d)",
             av, bv, pv, hv, nv, r1, got1, r4, got4);
    prev1 = r1;
    prev4 = r4;
  endtask

  initial begin
    logic [31:0] r, op_a, op_b, e_a, e_b;
    int c, nd, lx;

    g_resetn = 1'b0; start = 1'b0; flush = 1'b0;
    a = '0; b = '0; pw = '0; high = 1'b0; ncarry = 1'b0;
    prev1 = '0; prev4 = '0;
    repeat (2) @(negedge g_clk);
    check("rst_result", {res1, res4}, 64'd0);
    check("rst_ready_done", {60'd0, ready1, ready4, done1, done4}, 64'hC);
    g_resetn = 1'b1;

    // Directed products
    do_op(32'hFFFFFFFF, 32'h2, 3'd0, 1'b0, 1'b0, 1'b0, r);
    check("full_low", 64'(r), 64'hFFFFFFFE);
    do_op(32'hFFFFFFFF, 32'h2, 3'd0, 1'b1, 1'b0, 1'b0, r);
    check("full_high", 64'(r), 64'h00000001);
    do_op(32'h10FF0203, 32'h10FF0305, 3'd2, 1'b0, 1'b0, 1'b0, r);
    check("byte_low", 64'(r), 64'h0001060F);
    do_op(32'h10FF0203, 32'h10FF0305, 3'd2, 1'b1, 1'b0, 1'b0, r);
    check("byte_high", 64'(r), 64'h01FE0000);
    do_op(32'h3, 32'h3, 3'd0, 1'b0, 1'b1, 1'b0, r);
    check("clmul", 64'(r), 64'h5);

    // Random operations over all pack widths, legal and illegal
    repeat (24) do_op($urandom, $urandom, 3'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom), 1'b0, r);

    // start during RUN is ignored
    do_op($urandom, $urandom, 3'd0, 1'($urandom), 1'($urandom), 1'b1, r);

    // Make sure the held result is non-trivial before the flush test
    do_op(32'hDEADBEEF, 32'h12345679, 3'd1, 1'b0, 1'b0, 1'b0, r);

    // Flush on the 5th RUN cycle
    @(negedge g_clk);
    a = $urandom; b = $urandom; pw = 3'd0; start = 1'b1;
    @(negedge g_clk);
    start = 1'b0;
    repeat (4) @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    check("flush_ready", {62'd0, ready1, ready4}, 64'd3);
    check("flush_done", {62'd0, done1, done4}, 64'd0);
    check("flush_result", {res1, res4}, {prev1, prev4});
    nd = 0;
    repeat (40) begin @(negedge g_clk); if (done1 || done4) nd++; end
    check("flush_nodone", 64'(nd), 64'd0);

    // flush beats a simultaneous start
    start = 1'b1; flush = 1'b1; a = $urandom; b = $urandom; pw = 3'd0;
    @(negedge g_clk);
    start = 1'b0; flush = 1'b0;
    check("flush_dom_ready", {62'd0, ready1, ready4}, 64'd3);
    nd = 0;
    repeat (40) begin @(negedge g_clk); if (done1 || done4) nd++; end
    check("flush_dom_nodone", 64'(nd), 64'd0);
    $display("[TB] flush checks complete");

    // Asynchronous reset in the middle of RUN
    @(negedge g_clk);
    a = $urandom; b = $urandom; pw = 3'd0; start = 1'b1;
    @(negedge g_clk);
    start = 1'b0;
    repeat (3) @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    check("arst_result", {res1, res4}, 64'd0);
    check("arst_ready_done", {60'd0, ready1, ready4, done1, done4}, 64'hC);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("arst_release", {60'd0, ready1, ready4, done1, done4}, 64'hC);
    prev1 = '0; prev4 = '0;
    $display("[TB] mid-run reset checked");

    // LW=1 is illegal: zero result after two cycles
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 1'b0, 1'b0, 1'b0, r);
    check("illegal_res", 64'(r), 64'd0);
    do_op(32'h87654321, 32'h0F0F0F0F, 3'd3, 1'b1, 1'b0, 1'b0, r);

    // Back-to-back: start held high through DONE (SPC=1 instance checked)
    op_a = $urandom; op_b = $urandom;
    e_a = model(op_a, op_b, 2, 1'b0, 1'b0, 1, lx);
    e_b = model(op_b, op_a, 2, 1'b1, 1'b0, 1, lx);
    @(negedge g_clk);
    a = op_a; b = op_b; pw = 3'd2; high = 1'b0; ncarry = 1'b0; start = 1'b1;
    @(negedge g_clk);
    c = 1;
    while (!done1 && c < 100) begin @(negedge g_clk); c++; end
    check("b2b_lat1", 64'(c), 64'd9);
    check("b2b_res1", 64'(res1), 64'(e_a));
    a = op_b; b = op_a; high = 1'b1;
    @(negedge g_clk);
    start = 1'b0;
    check("b2b_busy", {62'd0, done1, ready1}, 64'd0);
    c = 1;
    while (!done1 && c < 100) begin @(negedge g_clk); c++; end
    check("b2b_lat2", 64'(c), 64'd9);
    check("b2b_res2", 64'(res1), 64'(e_b));
    $display("[TB] back-to-back results %h %h", e_a, e_b);
    repeat (20) @(negedge g_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
